// File: rtl/wash_pkg.sv
// Shared types and helpers for the wash cycle controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wash_pkg;

  // Sequencer states; IDLE must stay at 0 so a cleared register means idle.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FILL      = 4'd1,
    S_DETERGENT = 4'd2,
    S_LOAD      = 4'd3,
    S_WASH      = 4'd4,
    S_DRAIN     = 4'd5,
    S_SPIN      = 4'd6,
    S_DONE      = 4'd7,
    S_ERROR     = 4'd8
  } wash_state_e;

  // Default fill/drain watchdog limit in cycles.
  localparam int WDOG_TICKS_DEFAULT = 32;

  // Bits needed to hold a rinse count in 0..max_rinses.
  function automatic int rinse_w(input int max_rinses);
    return $clog2(max_rinses + 1);
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Loadable down-counter timing the WASH and SPIN phases; zero_o flags expiry.
// Latency: loaded value visible the cycle after load_i; counts down one per cycle and holds at 0.
// Backpressure: none; load_i always wins over the decrement.
module wash_phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Next count: load takes priority, otherwise decrement until 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wash_cycle_controller.sv
// Washing-machine sequencer: fill/detergent/load/wash/drain, N rinses, spin, done; abort; optional watchdog (WASH_WDOG_EN).
// Latency: inputs sampled at edge N change state after edge N; outputs are a Moore decode of registers.
// Backpressure: none; sensors are level-sampled only in the states that wait on them.
module wash_cycle_controller
  import wash_pkg::*;
#(
  parameter  int WASH_TICKS  = 8,
  parameter  int RINSE_TICKS = 4,
  parameter  int SPIN_TICKS  = 6,
  parameter  int MAX_RINSES  = 3,
  parameter  int TIMER_W     = 16,
  parameter  int WDOG_TICKS  = WDOG_TICKS_DEFAULT,
  localparam int RW          = rinse_w(MAX_RINSES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          door_close,
  input  logic          filled,
  input  logic          drained,
  input  logic          detergent_added,
  input  logic          clothes_loaded,
  input  logic          abort,
  input  logic [RW-1:0] rinse_sel,
  output logic          door_lock,
  output logic          motor_on,
  output logic          fill_valve_on,
  output logic          drain_valve_on,
  output logic          soap_wash,
  output logic          water_wash,
  output logic          done,
  output logic          error,
  output logic [RW-1:0] rinse_idx,
  output logic [3:0]    state
);

  wash_state_e        state_q, state_d;
  logic [RW-1:0]      rinse_tgt_q, rinse_tgt_d;
  logic [RW-1:0]      rinse_idx_q, rinse_idx_d;
  logic [RW-1:0]      idx_upd;
  logic               rinse_q, rinse_d;   // current pass is a rinse
  logic               abort_q, abort_d;   // drain in progress was forced by abort
  logic               soap_q, soap_d;     // soap phase finished in this run
  logic               tmr_load, tmr_zero;
  logic [TIMER_W-1:0] tmr_val;
  logic               wdog_hit;

`ifdef WASH_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_TICKS + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Count cycles spent in FILL/DRAIN; restart whenever a state is entered.
  always_comb begin
    wdog_d = '0;
    if ((state_q == S_FILL || state_q == S_DRAIN) && state_d == state_q) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end

  assign wdog_hit = (state_q == S_FILL || state_q == S_DRAIN) &&
                    (wdog_q == WDOG_W'(WDOG_TICKS - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  // Next-state and run bookkeeping; abort outranks sensors and timer, watchdog outranks sensors.
  always_comb begin
    state_d     = state_q;
    rinse_tgt_d = rinse_tgt_q;
    rinse_idx_d = rinse_idx_q;
    rinse_d     = rinse_q;
    abort_d     = abort_q;
    soap_d      = soap_q;
    idx_upd     = rinse_q ? rinse_idx_q + RW'(1) : rinse_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start && door_close) begin
          state_d     = S_FILL;
          rinse_tgt_d = (rinse_sel > RW'(MAX_RINSES)) ? RW'(MAX_RINSES) : rinse_sel;
          rinse_idx_d = '0;
          rinse_d     = 1'b0;
        end
      end
      S_FILL: begin
        if (abort) begin
          state_d = S_DRAIN;
          abort_d = 1'b1;
        end else if (wdog_hit) begin
          state_d = S_ERROR;
        end else if (filled) begin
          state_d = rinse_q ? S_WASH : S_DETERGENT;
        end
      end
      S_DETERGENT: begin
        if (abort) begin
          state_d = S_DRAIN;
          abort_d = 1'b1;
        end else if (detergent_added) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_DRAIN;
          abort_d = 1'b1;
        end else if (clothes_loaded) begin
          state_d = S_WASH;
        end
      end
      S_WASH: begin
        if (abort) begin
          state_d = S_DRAIN;
          abort_d = 1'b1;
        end else if (tmr_zero) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wdog_hit) begin
          state_d = S_ERROR;
        end else if (drained) begin
          if (abort_q) begin
            state_d = S_IDLE;
            abort_d = 1'b0;
          end else begin
            rinse_idx_d = idx_upd;
            if (idx_upd < rinse_tgt_q) begin
              rinse_d = 1'b1;
              state_d = S_FILL;
            end else begin
              state_d = S_SPIN;
            end
          end
        end
      end
      S_SPIN:  if (tmr_zero) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DRAIN) soap_d = 1'b1;
    if (state_d == S_IDLE)  soap_d = 1'b0;
  end

  // Load the phase timer with TICKS-1 on the edge entering WASH or SPIN.
  always_comb begin
    tmr_load = (state_d == S_WASH && state_q != S_WASH) ||
               (state_d == S_SPIN && state_q != S_SPIN);
    if (state_d == S_SPIN) tmr_val = TIMER_W'(SPIN_TICKS - 1);
    else if (rinse_q)      tmr_val = TIMER_W'(RINSE_TICKS - 1);
    else                   tmr_val = TIMER_W'(WASH_TICKS - 1);
  end

  wash_phase_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // State and run registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rinse_tgt_q <= '0;
      rinse_idx_q <= '0;
      rinse_q     <= 1'b0;
      abort_q     <= 1'b0;
      soap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rinse_tgt_q <= rinse_tgt_d;
      rinse_idx_q <= rinse_idx_d;
      rinse_q     <= rinse_d;
      abort_q     <= abort_d;
      soap_q      <= soap_d;
    end
  end

  // Moore output decode; ERROR drops every drive and the door lock.
  always_comb begin
    state          = state_q;
    rinse_idx      = rinse_idx_q;
    door_lock      = (state_q != S_IDLE) && (state_q != S_ERROR);
    motor_on       = (state_q == S_WASH) || (state_q == S_SPIN);
    fill_valve_on  = (state_q == S_FILL);
    drain_valve_on = (state_q == S_DRAIN) || (state_q == S_SPIN);
    done           = (state_q == S_DONE);
    soap_wash      = soap_q && (state_q != S_ERROR);
    water_wash     = rinse_q && (state_q != S_ERROR);
`ifdef WASH_WDOG_EN
    error          = (state_q == S_ERROR);
`else
    // No watchdog in this build: constant 0 (WDOG_TICKS is never negative).
    error          = (WDOG_TICKS < 0);
`endif
  end

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Randomized bench: builds an expected per-cycle timeline from phase rules, drives it, compares every cycle.
// Latency: outputs compared on the falling edge of each cycle.
// Backpressure: n/a.
module tb_wash_cycle_controller;
  import wash_pkg::*;

`ifdef WASH_WDOG_EN
  localparam int WD = 10;
`else
  localparam int WD = 32;
`endif
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, door_close, filled, drained, detergent_added, clothes_loaded, abort;
  logic [1:0] rinse_sel;
  logic       door_lock, motor_on, fill_valve_on, drain_valve_on;
  logic       soap_wash, water_wash, done, error;
  logic [1:0] rinse_idx;
  logic [3:0] state;

  always #5 clk = ~clk;

  wash_cycle_controller #(.WDOG_TICKS(WD)) u_dut (
    .clk(clk), .reset(reset), .start(start), .door_close(door_close),
    .filled(filled), .drained(drained), .detergent_added(detergent_added),
    .clothes_loaded(clothes_loaded), .abort(abort), .rinse_sel(rinse_sel),
    .door_lock(door_lock), .motor_on(motor_on), .fill_valve_on(fill_valve_on),
    .drain_valve_on(drain_valve_on), .soap_wash(soap_wash), .water_wash(water_wash),
    .done(done), .error(error), .rinse_idx(rinse_idx), .state(state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle of the expected timeline: inputs to drive and the reference view.
  typedef struct {
    logic [3:0] st;
    logic start, door, fil, drn, det, ld, ab;
    logic [1:0] sel;
    logic soap, water;
    int   ridx;
  } cyc_t;

  cyc_t tl[$];
  logic m_soap = 1'b0, m_water = 1'b0;
  int   m_ridx = 0;
  int   g_sel = 0;
  int   g_slen = 0;
  int   cyc_no = 0;

  function automatic logic [15:0] outs_now();
    return {6'd0, door_lock, motor_on, fill_valve_on, drain_valve_on,
            soap_wash, water_wash, done, error, rinse_idx};
  endfunction

  function automatic logic [15:0] outs_exp(input cyc_t e);
    logic dl, mo, fv, dv, dn, er, sw, ww;
    dl = (e.st != S_IDLE) && (e.st != S_ERROR);
    mo = (e.st == S_WASH) || (e.st == S_SPIN);
    fv = (e.st == S_FILL);
    dv = (e.st == S_DRAIN) || (e.st == S_SPIN);
    dn = (e.st == S_DONE);
    er = (e.st == S_ERROR);
    sw = er ? 1'b0 : e.soap;
    ww = er ? 1'b0 : e.water;
    return {6'd0, dl, mo, fv, dv, sw, ww, dn, er, 2'(e.ridx)};
  endfunction

  // Sensor phase length: the answering sensor rises on the last cycle.
  function automatic int sl();
    return (g_slen > 0) ? g_slen : int'($urandom_range(2, 4));
  endfunction

  // Append n cycles of state st; unused inputs get random noise.
  task automatic push(input logic [3:0] st, input int n, input bit ab_last);
    cyc_t e;
    for (int i = 0; i < n; i++) begin
      bit last;
      last = (i == n - 1);
      e.st = st;
      e.start = 1'($urandom); e.door = 1'($urandom);
      e.fil = 1'($urandom);   e.drn = 1'($urandom);
      e.det = 1'($urandom);   e.ld = 1'($urandom);
      e.sel = 2'($urandom);
      e.ab = (st == S_FILL || st == S_DETERGENT || st == S_LOAD || st == S_WASH) ?
             1'b0 : 1'($urandom);
      case (st)
        S_FILL:      e.fil = last;
        S_DETERGENT: e.det = last;
        S_LOAD:      e.ld  = last;
        S_DRAIN:     e.drn = last;
        S_IDLE: begin
          if (last) begin
            e.start = 1'b1; e.door = 1'b1; e.sel = 2'(g_sel);
          end else if (e.start) begin
            e.door = 1'b0;
          end
        end
        default: ;
      endcase
      if (ab_last && last) begin
        e.ab = 1'b1;
        if (st == S_FILL)      e.fil = 1'($urandom);
        if (st == S_DETERGENT) e.det = 1'($urandom);
        if (st == S_LOAD)      e.ld  = 1'($urandom);
      end
      e.soap = m_soap; e.water = m_water; e.ridx = m_ridx;
      tl.push_back(e);
    end
  endtask

  // Abortable phase: truncated to abort_k cycles if it is the chosen one.
  task automatic phase(input logic [3:0] st, input int natural, input int abort_ph,
                       input int abort_k, inout int ap, output bit ab);
    int len;
    ab = 1'b0;
    len = natural;
    if (ap == abort_ph) begin
      ab = 1'b1;
      len = (abort_k < natural) ? abort_k : natural;
    end
    ap++;
    push(st, len, ab);
  endtask

  task automatic abort_tail();
    m_soap = 1'b1;
    push(S_DRAIN, sl(), 1'b0);
    m_soap = 1'b0;
  endtask

  // One complete run described as a list of phases.
  task automatic do_run(input int sel, input int abort_ph, input int abort_k, input bit stop_in_spin);
    int tgt, ap;
    bit ab;
    g_sel = sel;
    push(S_IDLE, $urandom_range(1, 3), 1'b0);
    tgt = (sel > MAXR) ? MAXR : sel;
    m_ridx = 0; m_water = 1'b0; ap = 0;
    phase(S_FILL, sl(), abort_ph, abort_k, ap, ab);      if (ab) begin abort_tail(); return; end
    phase(S_DETERGENT, sl(), abort_ph, abort_k, ap, ab); if (ab) begin abort_tail(); return; end
    phase(S_LOAD, sl(), abort_ph, abort_k, ap, ab);      if (ab) begin abort_tail(); return; end
    phase(S_WASH, 8, abort_ph, abort_k, ap, ab);         if (ab) begin abort_tail(); return; end
    m_soap = 1'b1;
    push(S_DRAIN, sl(), 1'b0);
    for (int r = 0; r < tgt; r++) begin
      m_water = 1'b1;
      phase(S_FILL, sl(), abort_ph, abort_k, ap, ab); if (ab) begin abort_tail(); return; end
      phase(S_WASH, 4, abort_ph, abort_k, ap, ab);    if (ab) begin abort_tail(); return; end
      push(S_DRAIN, sl(), 1'b0);
      m_ridx++;
    end
    if (stop_in_spin) begin
      push(S_SPIN, 3, 1'b0);
      return;
    end
    push(S_SPIN, 6, 1'b0);
    push(S_DONE, 1, 1'b0);
    m_soap = 1'b0;
  endtask

  task automatic drive_zero();
    start = 0; door_close = 0; filled = 0; drained = 0;
    detergent_added = 0; clothes_loaded = 0; abort = 0; rinse_sel = 0;
  endtask

  // Play the timeline: drive after the rising edge, compare on the falling edge.
  task automatic execute();
    foreach (tl[i]) begin
      start = tl[i].start; door_close = tl[i].door; filled = tl[i].fil;
      drained = tl[i].drn; detergent_added = tl[i].det; clothes_loaded = tl[i].ld;
      abort = tl[i].ab; rinse_sel = tl[i].sel;
      @(negedge clk);
      check($sformatf("state@%0d", cyc_no), 16'(state), 16'(tl[i].st));
      check($sformatf("outs@%0d", cyc_no), outs_now(), outs_exp(tl[i]));
      cyc_no++;
      @(posedge clk);
      #1;
    end
    tl.delete();
  endtask

  // Assert reset between edges and confirm the asynchronous clear.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_state"}, 16'(state), 16'(S_IDLE));
    check({tag, "_outs"}, outs_now(), 16'd0);
    drive_zero();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_soap = 1'b0; m_water = 1'b0; m_ridx = 0;
  endtask

  initial begin
    drive_zero();
    #3;
    do_reset("reset");
    // Directed: single rinse with one-cycle sensor answers.
    g_slen = 2;
    do_run(1, -1, 0, 1'b0);
    g_slen = 0;
    do_run(0, -1, 0, 1'b0);
    do_run(3, -1, 0, 1'b0);
    // Abort on the third WASH cycle of the soap pass.
    do_run(1, 3, 3, 1'b0);
    execute();
    // Randomized runs with occasional aborts.
    for (int k = 0; k < 25; k++) begin
      int s, aph;
      s = $urandom_range(0, 3);
      aph = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3 + 2 * s)) : -1;
      do_run(s, aph, $urandom_range(1, 8), 1'b0);
    end
    execute();
    // Reset in the middle of SPIN, then a clean run.
    do_run(2, -1, 0, 1'b1);
    execute();
    do_reset("midspin");
    do_run(1, -1, 0, 1'b0);
    execute();
`ifdef WASH_WDOG_EN
    // Fill never completes: ERROR after WD cycles, held until reset.
    g_sel = 1;
    push(S_IDLE, 2, 1'b0);
    m_ridx = 0; m_water = 1'b0;
    push(S_FILL, WD, 1'b0);
    tl[tl.size() - 1].fil = 1'b0;
    push(S_ERROR, 5, 1'b0);
    execute();
    do_reset("wdog");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
